// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb: multi-read-port register file with a pending-bit
// scoreboard and a clear sweep that zeroes the array one entry per cycle.
// The array has no reset, so it can still map onto RAM.
// Optional build macro: RF_PARITY_EN. It adds one stored even-parity bit
// per entry and a per-port o_perr output.
module rf_multiport_sb #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 32,
  parameter int NRD       = 2,
  parameter int BYPASS_EN = 0,
  parameter int ZERO_REG  = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  output logic              o_ready,
  input  logic [NRD*AW-1:0] i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]    o_rbusy,
  input  logic              i_wen,
  input  logic [AW-1:0]     i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic              i_set_busy,
  input  logic [AW-1:0]     i_set_addr
`ifdef RF_PARITY_EN
  ,
  output logic [NRD-1:0]    o_perr
`endif
);

`ifdef RF_PARITY_EN
  localparam int MW = XLEN + 1;
`else
  localparam int MW = XLEN;
`endif

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             ready;
  logic             wr_ok, set_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [MW-1:0]    mem_wdata;
  logic [MW-1:0]    wr_word;

  logic [MW-1:0]    mem [DEPTH];

`ifdef RF_PARITY_EN
  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic par_f(input logic [XLEN-1:0] d);
    return ^d;
  endfunction
`endif

  // Entry 0 is never written or marked busy when hardwired to zero.
  assign wr_ok  = ready && i_wen &&
                  !((ZERO_REG != 0) && (i_waddr == '0));
  assign set_ok = ready && i_set_busy &&
                  !((ZERO_REG != 0) && (i_set_addr == '0));

`ifdef RF_PARITY_EN
  assign wr_word = {par_f(i_wdata), i_wdata};
`else
  assign wr_word = i_wdata;
`endif

  // Sequencer next state: sweep idx through the array, then sit in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (i_clear) begin
          idx_d = '0;
        end else if (idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (i_clear) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // Scoreboard next state: set beats writeback on the same address.
  always_comb begin
    busy_d = busy_q;
    if (!ready || i_clear) begin
      busy_d = '0;
    end else begin
      if (wr_ok)  busy_d[i_waddr]    = 1'b0;
      if (set_ok) busy_d[i_set_addr] = 1'b1;
    end
  end

  // Control registers with asynchronous reset back into the sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Single write port shared by the clear sweep and normal writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_waddr;
    mem_wdata = wr_word;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  // Storage array: no reset so it stays RAM-inferable.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign o_ready = ready;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [MW-1:0]   word;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            zero_hit;
    logic            byp_hit;

    assign ra       = i_raddr[k*AW +: AW];
    assign word     = mem[ra];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign byp_hit  = (BYPASS_EN != 0) && i_wen && (i_waddr == ra);

    // Read mux: blanked during sweep, then zero reg, bypass, array.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (ready && !zero_hit) begin
        if (byp_hit) begin
          data = i_wdata;
          busy = i_set_busy && (i_set_addr == ra);
        end else begin
          data = word[XLEN-1:0];
          busy = busy_q[ra];
        end
      end
    end

    assign o_rdata[k*XLEN +: XLEN] = data;
    assign o_rbusy[k]              = busy;

`ifdef RF_PARITY_EN
    logic perr;
    // Parity check only applies to data actually taken from the array.
    always_comb begin
      perr = 1'b0;
      if (ready && !zero_hit && !byp_hit)
        perr = word[XLEN] ^ par_f(word[XLEN-1:0]);
    end
    assign o_perr[k] = perr;
`endif
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Testbench for rf_multiport_sb: one instance without bypass and one with
// bypass share all inputs; a reference model feeds an expected-value queue.
`timescale 1ns/1ps
module tb_rf_multiport_sb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clear, wen, set_busy;
  logic [AW-1:0]     waddr, set_addr;
  logic [XLEN-1:0]   wdata;
  logic [NRD*AW-1:0] raddr;
  logic              ready0, ready1;
  logic [NRD*XLEN-1:0] rdata0, rdata1;
  logic [NRD-1:0]    rbusy0, rbusy1;
`ifdef RF_PARITY_EN
  logic [NRD-1:0]    perr0, perr1;
`endif

  rf_multiport_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS_EN(0), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_ready(ready0),
    .i_raddr(raddr), .o_rdata(rdata0), .o_rbusy(rbusy0),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_set_busy(set_busy), .i_set_addr(set_addr)
`ifdef RF_PARITY_EN
    , .o_perr(perr0)
`endif
  );

  rf_multiport_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS_EN(1), .ZERO_REG(1)) dut_bp (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_ready(ready1),
    .i_raddr(raddr), .o_rdata(rdata1), .o_rbusy(rbusy1),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_set_busy(set_busy), .i_set_addr(set_addr)
`ifdef RF_PARITY_EN
    , .o_perr(perr1)
`endif
  );

  typedef struct packed {logic [31:0] d; logic b;} exp_t;
  exp_t        sb[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_busy [DEPTH];
  int          tests = 0;
  int          failed = 0;

  // Advance one clock edge, updating the model with the driven inputs.
  task automatic tick();
    if (wen && waddr != 0) begin
      m_mem[waddr]  = wdata;
      m_busy[waddr] = 1'b0;
    end
    if (set_busy && set_addr != 0) m_busy[set_addr] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    clear = 0; wen = 0; set_busy = 0; waddr = '0; set_addr = '0; wdata = '0;
  endtask

  // Push expected read results: no-bypass ports 0,1 then bypass ports 0,1.
  task automatic push_reads();
    for (int bp = 0; bp < 2; bp++) begin
      for (int k = 0; k < NRD; k++) begin
        logic [AW-1:0] a;
        exp_t e;
        a = raddr[k*AW +: AW];
        if (a == 0) e = '{d: 32'h0, b: 1'b0};
        else if (bp == 1 && wen && waddr == a)
          e = '{d: wdata, b: (set_busy && set_addr == a)};
        else e = '{d: m_mem[a], b: m_busy[a]};
        sb.push_back(e);
      end
    end
  endtask

  // Count sampled cycles with ready low, bounded; returns at a negedge.
  task automatic count_sweep(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready0) break;
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 0; raddr = '0; idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (ready0 !== 0 || ready1 !== 0 || rbusy0 !== 0 || rbusy1 !== 0 || rdata0 !== 0 || rdata1 !== 0) begin
      failed++;
      $display("FAIL reset_state: ready %b/%b busy %b/%b data %h/%h, want all 0",
               ready0, ready1, rbusy0, rbusy1, rdata0, rdata1);
    end
    rst_n = 1;
    count_sweep(cnt);
    tests++;
    if (cnt !== 32 || ready1 !== 1) begin
      failed++;
      $display("FAIL reset_sweep_len: %0d cycles (ready_bp %b), want 32 (1)", cnt, ready1);
    end
    model_clear();
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(DEPTH - 1 - a), AW'(a)};
      push_reads();
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        exp_t e;
        logic [31:0] gd;
        logic gb;
        e = sb.pop_front();
        gd = (j < 2) ? rdata0[(j%2)*32 +: 32] : rdata1[(j%2)*32 +: 32];
        gb = (j < 2) ? rbusy0[j%2] : rbusy1[j%2];
        tests++;
        if (gd !== e.d || gb !== e.b) begin
          failed++;
          $display("FAIL post_reset_read r%0d slot%0d: got %h/%b, want %h/%b", a, j, gd, gb, e.d, e.b);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_bypass();
    for (int c = 0; c < 2; c++) begin
      wen = (c == 0); waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
      push_reads();
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        exp_t e;
        logic [31:0] gd;
        logic gb;
        e = sb.pop_front();
        gd = (j < 2) ? rdata0[(j%2)*32 +: 32] : rdata1[(j%2)*32 +: 32];
        gb = (j < 2) ? rbusy0[j%2] : rbusy1[j%2];
        tests++;
        if (gd !== e.d || gb !== e.b) begin
          failed++;
          $display("FAIL write_r5 cyc%0d slot%0d: got %h/%b, want %h/%b", c, j, gd, gb, e.d, e.b);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    for (int c = 0; c < 2; c++) begin
      wen = (c == 0); waddr = '0; wdata = 32'h12345678;
      set_busy = (c == 0); set_addr = '0; raddr = '0;
      push_reads();
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        exp_t e;
        logic [31:0] gd;
        logic gb;
        e = sb.pop_front();
        gd = (j < 2) ? rdata0[(j%2)*32 +: 32] : rdata1[(j%2)*32 +: 32];
        gb = (j < 2) ? rbusy0[j%2] : rbusy1[j%2];
        tests++;
        if (gd !== e.d || gb !== e.b) begin
          failed++;
          $display("FAIL zero_reg cyc%0d slot%0d: got %h/%b, want %h/%b", c, j, gd, gb, e.d, e.b);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  // Rows: wen, wdata, set_busy; each row is followed by an idle read cycle.
  task automatic test_scoreboard();
    logic [32:0] rows [3];
    logic        sets [3];
    rows[0] = {1'b0, 32'h0};        sets[0] = 1'b1;
    rows[1] = {1'b1, 32'hA5A5_0707}; sets[1] = 1'b1;
    rows[2] = {1'b1, 32'h0F0F_7777}; sets[2] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        wen = (c == 0) ? rows[r][32] : 1'b0;
        wdata = rows[r][31:0]; waddr = 5'd7;
        set_busy = (c == 0) ? sets[r] : 1'b0; set_addr = 5'd7;
        raddr = {5'd7, 5'd7};
        push_reads();
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
          exp_t e;
          logic [31:0] gd;
          logic gb;
          e = sb.pop_front();
          gd = (j < 2) ? rdata0[(j%2)*32 +: 32] : rdata1[(j%2)*32 +: 32];
          gb = (j < 2) ? rbusy0[j%2] : rbusy1[j%2];
          tests++;
          if (gd !== e.d || gb !== e.b) begin
            failed++;
            $display("FAIL scoreboard_r7 row%0d cyc%0d slot%0d: got %h/%b, want %h/%b",
                     r, c, j, gd, gb, e.d, e.b);
          end
        end
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] prev;
    prev = 5'd5;
    for (int i = 0; i < 8; i++) begin
      waddr = AW'($urandom_range(1, DEPTH - 1)); wdata = $urandom; wen = 1;
      raddr = {prev, waddr};
      push_reads();
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        exp_t e;
        logic [31:0] gd;
        logic gb;
        e = sb.pop_front();
        gd = (j < 2) ? rdata0[(j%2)*32 +: 32] : rdata1[(j%2)*32 +: 32];
        gb = (j < 2) ? rbusy0[j%2] : rbusy1[j%2];
        tests++;
        if (gd !== e.d || gb !== e.b) begin
          failed++;
          $display("FAIL back_to_back i%0d slot%0d: got %h/%b, want %h/%b", i, j, gd, gb, e.d, e.b);
        end
      end
      prev = waddr;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int cnt;
    bit bad;
    for (int a = 1; a <= 3; a++) begin
      wen = 1; waddr = AW'(a); wdata = 32'h1000_0000 + a;
      set_busy = (a == 2); set_addr = 5'd2;
      tick();
    end
    idle_inputs();
    clear = 1;
    tick();
    clear = 0;
    wen = 1; waddr = 5'd1; wdata = 32'hFFFF_FFFF; set_busy = 1; set_addr = 5'd3;
    raddr = {5'd2, 5'd1};
    bad = 0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready0) break;
      cnt++;
      if (rdata0 !== 0 || rdata1 !== 0 || rbusy0 !== 0 || rbusy1 !== 0) bad = 1;
    end
    idle_inputs();
    tests++;
    if (cnt !== 32) begin
      failed++;
      $display("FAIL clear_sweep_len: %0d cycles, want 32", cnt);
    end
    tests++;
    if (bad !== 1'b0) begin
      failed++;
      $display("FAIL clear_outputs_blank: nonzero read seen during sweep, want all 0");
    end
    model_clear();
    @(posedge clk); #1;
    for (int a = 1; a <= 3; a++) begin
      raddr = {AW'(a), AW'(a)};
      push_reads();
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        exp_t e;
        logic [31:0] gd;
        logic gb;
        e = sb.pop_front();
        gd = (j < 2) ? rdata0[(j%2)*32 +: 32] : rdata1[(j%2)*32 +: 32];
        gb = (j < 2) ? rbusy0[j%2] : rbusy1[j%2];
        tests++;
        if (gd !== e.d || gb !== e.b) begin
          failed++;
          $display("FAIL after_clear r%0d slot%0d: got %h/%b, want %h/%b", a, j, gd, gb, e.d, e.b);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    set_busy = 1; set_addr = 5'd4; tick();
    idle_inputs();
    wen = 1; waddr = 5'd6; wdata = 32'h0000_0011; tick();
    idle_inputs();
    clear = 1; tick();
    clear = 0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1;
    count_sweep(cnt);
    tests++;
    if (cnt !== 32) begin
      failed++;
      $display("FAIL reset_mid_sweep_len: %0d cycles, want 32", cnt);
    end
    model_clear();
    @(posedge clk); #1;
    raddr = {5'd6, 5'd4};
    push_reads();
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      exp_t e;
      logic [31:0] gd;
      logic gb;
      e = sb.pop_front();
      gd = (j < 2) ? rdata0[(j%2)*32 +: 32] : rdata1[(j%2)*32 +: 32];
      gb = (j < 2) ? rbusy0[j%2] : rbusy1[j%2];
      tests++;
      if (gd !== e.d || gb !== e.b) begin
        failed++;
        $display("FAIL after_mid_reset slot%0d: got %h/%b, want %h/%b", j, gd, gb, e.d, e.b);
      end
    end
    tick();
  endtask

`ifdef RF_PARITY_EN
  task automatic test_parity();
    wen = 1; waddr = 5'd9; wdata = 32'h0000_00F1; tick();
    idle_inputs();
    raddr = {5'd10, 5'd9};
    @(negedge clk);
    tests++;
    if (perr0 !== 2'b00) begin
      failed++;
      $display("FAIL parity_clean: perr %b, want 00", perr0);
    end
    dut.mem[9][0] = ~dut.mem[9][0];
    #1;
    tests++;
    if (perr0 !== 2'b01 || perr1 !== 2'b00) begin
      failed++;
      $display("FAIL parity_flip: perr %b/%b, want 01/00", perr0, perr1);
    end
    @(posedge clk); #1;
    wen = 1; waddr = 5'd9; wdata = 32'h0000_00F1; tick();
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
`ifdef RF_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
